// File: rtl/pio_pkg.sv
// Shared definitions for the PIO state-machine datapath blocks.
//   WIDTH        : ISR / FIFO data width (fixed at 32)
//   CNT_W        : width of bit counts that must represent 0..32
//   shift_dir_t  : shift direction of the ISR
//   decode_count : 5-bit count field where 0 means 32 -> 6-bit count
package pio_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 6;

    typedef enum logic {
        DirLeft  = 1'b0,
        DirRight = 1'b1
    } shift_dir_t;

    function automatic logic [CNT_W-1:0] decode_count(input logic [4:0] enc);
        return (enc == 5'd0) ? 6'd32 : {1'b0, enc};
    endfunction

endpackage

// File: rtl/isr_shift_merge.sv
// Combinational merge of new IN data into the ISR.
//   isr     : current ISR contents
//   in_data : IN source value (only the low n bits are used)
//   n       : bit count, 1..32
//   dir     : DirLeft shifts data in at the LSB end, DirRight at the MSB end
//   s       : merged shift result
module isr_shift_merge
    import pio_pkg::*;
(
    input  logic [WIDTH-1:0] isr,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] n,
    input  shift_dir_t       dir,
    output logic [WIDTH-1:0] s
);

    logic [CNT_W-1:0] rsh;
    logic [WIDTH-1:0] mask;

    // Shifts by exactly 32 yield zero, so n=32 collapses to s=in_data without a special case.
    assign rsh  = 6'd32 - n;
    assign mask = ~({WIDTH{1'b1}} << n);

    always_comb begin
        if (dir == DirRight) begin
            s = (isr >> n) | (in_data << rsh);
        end else begin
            s = (isr << n) | (in_data & mask);
        end
    end

endmodule

// File: rtl/pio_isr.sv
// PIO input shift register with autopush. Executes IN / PUSH / MOV-to-ISR and drives the
// RX fifo push handshake and the decoder stall.
//   clk, reset           : clock, synchronous active-high reset
//   en                   : execute tick; when low nothing happens
//   shift_right          : ISR shift direction
//   autopush, thresh     : autopush enable and threshold (0 means 32)
//   in_valid/data/count  : IN instruction (count 0 means 32)
//   push_req/iffull/block: PUSH instruction and its flags
//   mov_valid, mov_data  : MOV to ISR
//   fifo_full            : RX fifo full
//   fifo_push, fifo_din  : push strobe and data to the RX fifo
//   stall                : instruction must be re-issued
//   overflow             : non-blocking PUSH dropped data because the fifo was full
//   isr, isr_count       : ISR contents and saturating shift count
module pio_isr
    import pio_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             shift_right,
    input  logic             autopush,
    input  logic [4:0]       thresh,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [4:0]       in_count,
    input  logic             push_req,
    input  logic             push_iffull,
    input  logic             push_block,
    input  logic             mov_valid,
    input  logic [WIDTH-1:0] mov_data,
    input  logic             fifo_full,
    output logic             fifo_push,
    output logic [WIDTH-1:0] fifo_din,
    output logic             stall,
    output logic             overflow,
    output logic [WIDTH-1:0] isr,
    output logic [CNT_W-1:0] isr_count
);

    logic [WIDTH-1:0] isr_q, isr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] thr, n;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] c;
    logic [WIDTH-1:0] s;
    shift_dir_t       dir;

    assign thr = decode_count(thresh);
    assign n   = decode_count(in_count);
    assign dir = shift_right ? DirRight : DirLeft;
    assign sum = {1'b0, count_q} + {1'b0, n};
    assign c   = (sum > 7'd32) ? 6'd32 : sum[CNT_W-1:0];

    isr_shift_merge u_merge (
        .isr     (isr_q),
        .in_data (in_data),
        .n       (n),
        .dir     (dir),
        .s       (s)
    );

    always_comb begin
        isr_d     = isr_q;
        count_d   = count_q;
        fifo_push = 1'b0;
        fifo_din  = '0;
        stall     = 1'b0;
        overflow  = 1'b0;
        if (en) begin
            if (mov_valid) begin
                isr_d   = mov_data;
                count_d = '0;
            end else if (push_req) begin
                if (push_iffull && (count_q < thr)) begin
                    // Below threshold: PUSH IfFull retires as a no-op.
                end else if (!fifo_full) begin
                    fifo_push = 1'b1;
                    fifo_din  = isr_q;
                    isr_d     = '0;
                    count_d   = '0;
                end else if (push_block) begin
                    stall = 1'b1;
                end else begin
                    overflow = 1'b1;
                    isr_d    = '0;
                    count_d  = '0;
                end
            end else if (in_valid) begin
                if (autopush && (c >= thr)) begin
                    if (fifo_full) begin
                        stall = 1'b1;
                    end else begin
                        fifo_push = 1'b1;
                        fifo_din  = s;
                        isr_d     = '0;
                        count_d   = '0;
                    end
                end else begin
                    isr_d   = s;
                    count_d = c;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            isr_q   <= '0;
            count_q <= '0;
        end else begin
            isr_q   <= isr_d;
            count_q <= count_d;
        end
    end

    assign isr       = isr_q;
    assign isr_count = count_q;

endmodule

// File: tb/tb_pio_isr.sv
module tb_pio_isr;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        shift_right;
    logic        autopush;
    logic [4:0]  thresh;
    logic        in_valid;
    logic [31:0] in_data;
    logic [4:0]  in_count;
    logic        push_req;
    logic        push_iffull;
    logic        push_block;
    logic        mov_valid;
    logic [31:0] mov_data;
    logic        fifo_full;
    logic        fifo_push;
    logic [31:0] fifo_din;
    logic        stall;
    logic        overflow;
    logic [31:0] isr;
    logic [5:0]  isr_count;

    int tests = 0;
    int fails = 0;

    // Reference state
    longint unsigned m_isr = 0;
    int              m_cnt = 0;

    always #5 clk = ~clk;

    pio_isr dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .shift_right (shift_right),
        .autopush    (autopush),
        .thresh      (thresh),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_count    (in_count),
        .push_req    (push_req),
        .push_iffull (push_iffull),
        .push_block  (push_block),
        .mov_valid   (mov_valid),
        .mov_data    (mov_data),
        .fifo_full   (fifo_full),
        .fifo_push   (fifo_push),
        .fifo_din    (fifo_din),
        .stall       (stall),
        .overflow    (overflow),
        .isr         (isr),
        .isr_count   (isr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Behavioural model: bit counts as integers, shift merge as multiply/divide by 2^n.
    task automatic model(output logic e_push, output logic [31:0] e_din, output logic e_stall,
                         output logic e_ovf, output longint unsigned n_isr, output int n_cnt);
        longint unsigned p, s, d;
        int t, n, c;
        t = (thresh == 0) ? 32 : int'(thresh);
        n = (in_count == 0) ? 32 : int'(in_count);
        e_push = 0; e_din = 0; e_stall = 0; e_ovf = 0;
        n_isr = m_isr; n_cnt = m_cnt;
        p = longint'(1) << n;
        d = longint'(in_data) % p;
        if (shift_right) s = (m_isr / p) + d * ((longint'(1) << 32) / p);
        else             s = ((m_isr * p) + d) % (longint'(1) << 32);
        c = (m_cnt + n > 32) ? 32 : m_cnt + n;
        if (!en) begin
        end else if (mov_valid) begin
            n_isr = mov_data; n_cnt = 0;
        end else if (push_req) begin
            if (push_iffull && m_cnt < t) begin
            end else if (!fifo_full) begin
                e_push = 1; e_din = m_isr[31:0]; n_isr = 0; n_cnt = 0;
            end else if (push_block) begin
                e_stall = 1;
            end else begin
                e_ovf = 1; n_isr = 0; n_cnt = 0;
            end
        end else if (in_valid) begin
            if (autopush && c >= t) begin
                if (fifo_full) e_stall = 1;
                else begin
                    e_push = 1; e_din = s[31:0]; n_isr = 0; n_cnt = 0;
                end
            end else begin
                n_isr = s; n_cnt = c;
            end
        end
    endtask

    // One clock: check combinational outputs mid-cycle, then registered state after the edge.
    task automatic tick(input string tag);
        logic e_push, e_stall, e_ovf;
        logic [31:0] e_din;
        longint unsigned n_isr;
        int n_cnt;
        model(e_push, e_din, e_stall, e_ovf, n_isr, n_cnt);
        #2;
        if (!reset) begin
            chk({tag, ".push"}, 32'(fifo_push), 32'(e_push));
            chk({tag, ".stall"}, 32'(stall), 32'(e_stall));
            chk({tag, ".ovf"}, 32'(overflow), 32'(e_ovf));
            if (e_push) chk({tag, ".din"}, fifo_din, e_din);
        end
        @(posedge clk);
        #1;
        if (reset) begin
            m_isr = 0; m_cnt = 0;
        end else begin
            m_isr = n_isr; m_cnt = n_cnt;
        end
        chk({tag, ".isr"}, isr, m_isr[31:0]);
        chk({tag, ".cnt"}, 32'(isr_count), 32'(m_cnt));
    endtask

    task automatic idle();
        en = 1; in_valid = 0; push_req = 0; mov_valid = 0;
        push_iffull = 0; push_block = 0; fifo_full = 0;
    endtask

    initial begin
        reset = 1; shift_right = 0; autopush = 0; thresh = 0;
        in_data = 0; in_count = 0; mov_data = 0;
        idle();
        tick("rst0");
        tick("rst1");
        reset = 0;
        #2;
        chk("rst.push", 32'(fifo_push), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        chk("rst.ovf", 32'(overflow), 32'd0);
        chk("rst.isr", isr, 32'd0);

        // 1: shift-left IN n=8 of 0xAB four times, no autopush
        in_valid = 1; in_count = 8; in_data = 32'hAB;
        for (int i = 0; i < 4; i++) tick("t1");
        chk("t1.isr_abs", isr, 32'hABABABAB);
        chk("t1.cnt_abs", 32'(isr_count), 32'd32);

        // 2: autopush T=16, shift-right n=8 of 0x12 then 0x34
        idle(); mov_valid = 1; mov_data = 0; tick("t2.clr");
        idle(); autopush = 1; thresh = 16; shift_right = 1; in_valid = 1; in_count = 8;
        in_data = 32'h12; tick("t2.a");
        in_data = 32'h34;
        #2;
        chk("t2.push_abs", 32'(fifo_push), 32'd1);
        chk("t2.din_abs", fifo_din, 32'h34120000);
        #1;
        tick("t2.b");
        chk("t2.cnt_abs", 32'(isr_count), 32'd0);

        // 3: same with fifo full for 3 cycles
        in_data = 32'h12; tick("t3.a");
        in_data = 32'h34; fifo_full = 1;
        for (int i = 0; i < 3; i++) tick("t3.stall");
        chk("t3.hold", isr, 32'h12000000);
        fifo_full = 0;
        tick("t3.go");

        // 4: PUSH IfFull below threshold, then non-blocking PUSH with fifo full
        idle(); shift_right = 0; autopush = 0; in_valid = 1; in_count = 8; in_data = 32'h5A;
        tick("t4.in");
        idle(); push_req = 1; push_iffull = 1; tick("t4.iffull");
        push_iffull = 0; push_block = 0; fifo_full = 1;
        #2;
        chk("t4.ovf_abs", 32'(overflow), 32'd1);
        #1;
        tick("t4.ovf");
        chk("t4.isr_abs", isr, 32'd0);

        // 5: MOV wins over PUSH
        idle(); push_req = 1; mov_valid = 1; mov_data = 32'hDEADBEEF; tick("t5");
        chk("t5.isr_abs", isr, 32'hDEADBEEF);

        // 6: n=32 with T=32 pushes immediately; en=0 cycles change nothing
        idle(); autopush = 1; thresh = 0; in_valid = 1; in_count = 0; in_data = 32'hCAFEF00D;
        en = 0; tick("t6.off0"); tick("t6.off1");
        en = 1; tick("t6.push");
        en = 0; tick("t6.off2");

        // Reset mid-stall
        idle(); autopush = 1; thresh = 16; in_valid = 1; in_count = 8; in_data = 32'h77;
        tick("rs.a");
        fifo_full = 1; tick("rs.stall");
        reset = 1; tick("rs.rst");
        reset = 0; tick("rs.after");

        // Random stimulus against the model
        for (int i = 0; i < 400; i++) begin
            en          = ($urandom_range(0, 9) != 0);
            shift_right = 1'($urandom);
            autopush    = 1'($urandom);
            thresh      = 5'($urandom);
            in_valid    = ($urandom_range(0, 3) != 0);
            in_data     = $urandom;
            in_count    = 5'($urandom);
            push_req    = ($urandom_range(0, 4) == 0);
            push_iffull = 1'($urandom);
            push_block  = 1'($urandom);
            mov_valid   = ($urandom_range(0, 9) == 0);
            mov_data    = $urandom;
            fifo_full   = ($urandom_range(0, 2) == 0);
            tick("rnd");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
